pmem_load_ctrl: RTL and testbench

Boot/load controller for the pipelined RISC-V core. It receives a program as a byte stream from the chip's dedicated inputs and assembles little-endian 32-bit words. It writes them sequentially into program memory while holding the pipeline stalled, then flushes the fetch/decode/execute/writeback pipeline and releases the core to run from PC 0. It sits between the top-level IO pins and the program_memory, program_counter and pipeline-register enables.

---
 rtl/pmem_load_if.sv | 29 ++
 rtl/pmem_load_ctrl.sv | 132 +++++++++++++
 tb/tb_pmem_load_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_load_if.sv
// Host-side byte stream and program-memory / pipeline-control bundle for the
// boot loader. The host (pins) side is the master; the controller is the slave.
interface pmem_load_if #(
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready;
  logic              pmem_we;
  logic [ADDR_W-1:0] pmem_waddr;
  logic [31:0]       pmem_wdata;
  logic              cpu_stall;
  logic              cpu_flush;
  logic              load_done;
  logic [ADDR_W:0]   word_count;

  modport master (
    output load_start, byte_valid, byte_in,
    input  byte_ready, pmem_we, pmem_waddr, pmem_wdata,
           cpu_stall, cpu_flush, load_done, word_count
  );

  modport slave (
    input  load_start, byte_valid, byte_in,
    output byte_ready, pmem_we, pmem_waddr, pmem_wdata,
           cpu_stall, cpu_flush, load_done, word_count
  );
endinterface

// File: rtl/pmem_load_ctrl.sv
// Boot/load controller: header byte gives the word count, following bytes are
// packed little-endian into 32-bit words and written to program memory while
// the core is stalled; afterwards the pipeline is flushed and the core runs.
//
// state | meaning
// IDLE  | after reset, core stalled, waiting for load_start
// HDR   | waiting for the word-count header byte
// DATA  | collecting the 4 bytes of the next word
// WRITE | single-cycle program memory write strobe
// FLUSH | pipeline flush for FLUSH_CYCLES cycles
// RUN   | core released, load_start begins a reload
module pmem_load_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int FLUSH_CYCLES = 3
) (
  input logic        clk,
  input logic        rst,
  pmem_load_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int FW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, FLUSH, RUN} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   word_count_q;
  logic [ADDR_W:0]   word_count_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx_q;
  logic [FW-1:0]     flush_cnt_q;
  logic              pmem_we_q;
  logic              cpu_stall_q;
  logic              cpu_flush_q;
  logic              load_done_q;
  logic              byte_ready;
  logic              accept;

  // byte_ready is the only unregistered output: a pure decode of the state
  assign byte_ready   = (state_q == HDR) || (state_q == DATA);
  assign accept       = byte_ready & bus.byte_valid;
  assign word_count_d = word_count_q + (ADDR_W+1)'(1);

  // Sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_count_q <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      flush_cnt_q  <= '0;
      pmem_we_q    <= 1'b0;
      cpu_stall_q  <= 1'b1;
      cpu_flush_q  <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_start) state_q <= HDR;
        end
        HDR: begin
          if (accept) begin
            // zero or oversize header means "fill the whole memory"
            if (bus.byte_in == 8'd0 || 32'(bus.byte_in) > DEPTH)
              n_q <= (ADDR_W+1)'(DEPTH);
            else
              n_q <= (ADDR_W+1)'(bus.byte_in);
            word_count_q <= '0;
            waddr_q      <= '0;
            idx_q        <= '0;
            state_q      <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            wdata_q[{idx_q, 3'b000} +: 8] <= bus.byte_in;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              pmem_we_q <= 1'b1;
              state_q   <= WRITE;
            end
          end
        end
        WRITE: begin
          pmem_we_q    <= 1'b0;
          word_count_q <= word_count_d;
          waddr_q      <= waddr_q + ADDR_W'(1);
          idx_q        <= '0;
          if (word_count_d == n_q) begin
            cpu_flush_q <= 1'b1;
            flush_cnt_q <= FW'(FLUSH_CYCLES - 1);
            state_q     <= FLUSH;
          end else begin
            state_q <= DATA;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            cpu_flush_q <= 1'b0;
            cpu_stall_q <= 1'b0;
            load_done_q <= 1'b1;
            state_q     <= RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1);
          end
        end
        RUN: begin
          if (bus.load_start) begin
            cpu_stall_q <= 1'b1;
            load_done_q <= 1'b0;
            state_q     <= HDR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.pmem_we    = pmem_we_q;
  assign bus.pmem_waddr = waddr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.cpu_stall  = cpu_stall_q;
  assign bus.cpu_flush  = cpu_flush_q;
  assign bus.load_done  = load_done_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_pmem_load_ctrl.sv
// Self-checking bench for pmem_load_ctrl: directed and randomized loads
// compared against a word-list model derived from the byte stream.
module tb_pmem_load_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int FLUSH  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pmem_load_if #(.ADDR_W(ADDR_W)) bus ();

  pmem_load_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Passive monitor sampled mid-cycle: accepted bytes, writes, flush runs
  int          acc_cnt = 0;
  int          we_cnt = 0;
  int          we_bad = 0;
  int          flush_run = 0;
  int          last_flush_run = 0;
  logic [31:0] wq_data [0:1023];
  logic [31:0] wq_addr [0:1023];

  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    if (bus.pmem_we === 1'b1) begin
      if (we_cnt < 1024) begin
        wq_data[we_cnt] <= bus.pmem_wdata;
        wq_addr[we_cnt] <= 32'(bus.pmem_waddr);
      end
      we_cnt <= we_cnt + 1;
      if (bus.byte_ready === 1'b1) we_bad <= we_bad + 1;
    end
    if (bus.cpu_flush === 1'b1) flush_run <= flush_run + 1;
    else begin
      if (flush_run > 0) last_flush_run <= flush_run;
      flush_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one byte after 'gap' idle cycles; optional load_start alongside
  task automatic send_byte(input logic [7:0] b, input int gap, input logic ls);
    int   budget;
    logic acc;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    bus.load_start = ls;
    budget = 50;
    acc    = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = bus.byte_ready;
      tick();
      bus.load_start = 1'b0;
      budget--;
    end
    bus.byte_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Full load from IDLE or RUN, checked against the word-list model
  task automatic run_load(input logic [7:0] hdr, input logic [7:0] dat[$],
                          input int max_gap, input int ls_at, input bit coincide,
                          input string tag);
    int          n, we0, acc0, got, budget;
    logic [31:0] exp_w;
    n    = (hdr == 8'd0 || int'(hdr) > DEPTH) ? DEPTH : int'(hdr);
    we0  = we_cnt;
    acc0 = acc_cnt;
    bus.load_start = 1'b1;
    if (coincide) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hA5;
    end
    @(negedge clk);
    chk({tag, "_ready_at_start"}, 32'(bus.byte_ready), 32'd0);
    tick();
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_stall_after_start"}, 32'(bus.cpu_stall), 32'd1);
    chk({tag, "_done_after_start"}, 32'(bus.load_done), 32'd0);
    chk({tag, "_acc_after_start"}, 32'(acc_cnt - acc0), 32'd0);
    tick();
    send_byte(hdr, $urandom_range(0, max_gap), 1'b0);
    for (int i = 0; i < 4 * n; i++)
      send_byte(dat[i], $urandom_range(0, max_gap), logic'(i == ls_at));
    budget = 40;
    while (bus.load_done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (bus.load_done !== 1'b1) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    tick();
    got = we_cnt - we0;
    chk({tag, "_writes"}, 32'(got), 32'(n));
    for (int k = 0; k < n && k < got; k++) begin
      exp_w = {dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]};
      chk($sformatf("%s_addr%0d", tag, k), wq_addr[we0+k], 32'(k % DEPTH));
      chk($sformatf("%s_data%0d", tag, k), wq_data[we0+k], exp_w);
    end
    chk({tag, "_accepted"}, 32'(acc_cnt - acc0), 32'(1 + 4 * n));
    chk({tag, "_flush_len"}, 32'(last_flush_run), 32'(FLUSH));
    chk({tag, "_stall_run"}, 32'(bus.cpu_stall), 32'd0);
    chk({tag, "_flush_run"}, 32'(bus.cpu_flush), 32'd0);
    chk({tag, "_done_run"}, 32'(bus.load_done), 32'd1);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'(n));
    chk({tag, "_waddr_end"}, 32'(bus.pmem_waddr), 32'(n % DEPTH));
  endtask

  initial begin
    logic [7:0] d[$];
    int         acc0, we0;

    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;

    // reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_we", 32'(bus.pmem_we), 32'd0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_wc", 32'(bus.word_count), 32'd0);
    tick();

    // directed two-word load, one byte per cycle
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(8'h02, d, 0, -1, 1'b0, "two_word");

    // same stream with gaps, reload from RUN
    run_load(8'h02, d, 2, -1, 1'b0, "two_word_gaps");

    // reset in the middle of DATA after two data bytes
    we0 = we_cnt;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 32'(bus.cpu_stall), 32'd1);
    chk("midrst_done", 32'(bus.load_done), 32'd0);
    chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_wc", 32'(bus.word_count), 32'd0);
    chk("midrst_waddr", 32'(bus.pmem_waddr), 32'd0);
    chk("midrst_wdata", bus.pmem_wdata, 32'd0);
    chk("midrst_flush", 32'(bus.cpu_flush), 32'd0);
    tick();
    acc0 = acc_cnt;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h55;
    repeat (5) tick();
    bus.byte_valid = 1'b0;
    tick();
    chk("midrst_idle_acc", 32'(acc_cnt - acc0), 32'd0);
    chk("midrst_no_we", 32'(we_cnt - we0), 32'd0);

    // full-depth load, header 0, word k = k
    d.delete();
    for (int k = 0; k < DEPTH; k++) begin
      d.push_back(8'(k));
      d.push_back(8'h00);
      d.push_back(8'h00);
      d.push_back(8'h00);
    end
    run_load(8'h00, d, 0, -1, 1'b0, "full_depth");

    // bytes of a 33rd word must not be accepted
    acc0 = acc_cnt;
    we0  = we_cnt;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h77;
    repeat (8) tick();
    bus.byte_valid = 1'b0;
    tick();
    chk("extra_word_acc", 32'(acc_cnt - acc0), 32'd0);
    chk("extra_word_we", 32'(we_cnt - we0), 32'd0);

    // oversize header saturates to full depth
    d.delete();
    for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
    run_load(8'hFF, d, 1, -1, 1'b0, "oversize");

    // reload: coincident load_start/byte_valid, load_start during DATA ignored
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(8'h01, d, 0, 2, 1'b1, "reload");

    // randomized loads
    for (int t = 0; t < 4; t++) begin
      logic [7:0] h;
      h = 8'($urandom_range(0, 40));
      d.delete();
      for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
      run_load(h, d, 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $sformatf("rand%0d", t));
    end

    chk("we_while_ready", 32'(we_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
